// File: rtl/pwm_ramp_sequencer_if.sv
// Command channel of the PWM ramp sequencer: valid/ready handshake carrying
// a channel index, a target duty and a ramp step. The master issues commands
// and the sequencer is the slave.
interface pwm_ramp_sequencer_if #(
  parameter int CH     = 4,
  parameter int DW     = 5,
  parameter int STEP_W = 3
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CHW-1:0]    cmd_ch;
  logic [DW:0]       cmd_duty;
  logic [STEP_W-1:0] cmd_step;

  modport master (
    output cmd_valid,
    output cmd_ch,
    output cmd_duty,
    output cmd_step,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ch,
    input  cmd_duty,
    input  cmd_step,
    output cmd_ready
  );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Multi-channel PWM duty sequencer. One free-running period counter is shared
// by all channels; each channel ramps its current duty toward a commanded
// target by a fixed step once per PWM period, so duty only changes at period
// boundaries and the outputs never glitch.
// Optional feature: define PWM_SEQ_IRQ_EN to add a sticky-done interrupt
// (ports irq / irq_clr).
module pwm_ramp_sequencer #(
  parameter int CH     = 4,
  parameter int DW     = 5,
  parameter int STEP_W = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  pwm_ramp_sequencer_if.slave        cmd,
  output logic [CH-1:0]              pwm_out,
  output logic [CH-1:0]              busy,
  output logic [CH-1:0]              done,
  output logic                       period_tick
`ifdef PWM_SEQ_IRQ_EN
  ,
  output logic                       irq,
  input  logic                       irq_clr
`endif
);

  // Ramp arithmetic runs two bits wider than the counter so that
  // cur + step and tgt + step can never wrap.
  localparam int              CW      = DW + 2;
  localparam logic [DW:0]     FULL    = {1'b1, {DW{1'b0}}};
  localparam logic [DW-1:0]   CNT_MAX = '1;

  typedef enum logic {S_IDLE, S_RAMP} state_t;

  logic [DW-1:0]     cnt_q;
  logic              b_evt;
  logic              accept;
  logic [DW:0]       duty_clamped;
  logic [CH-1:0]     sel;

  logic [DW:0]       cur_q  [CH];
  logic [DW:0]       cur_d  [CH];
  logic [DW:0]       tgt_q  [CH];
  logic [DW:0]       tgt_d  [CH];
  logic [STEP_W-1:0] step_q [CH];
  logic [STEP_W-1:0] step_d [CH];
  state_t            state_q[CH];
  state_t            state_d[CH];
  logic [CH-1:0]     done_d;

  // One step toward the target; a zero step jumps straight there.
  function automatic logic [DW:0] ramp_next(input logic [DW:0]       cur,
                                            input logic [DW:0]       tgt,
                                            input logic [STEP_W-1:0] step);
    logic [CW-1:0] c;
    logic [CW-1:0] t;
    logic [CW-1:0] s;
    logic [DW:0]   r;
    c = CW'(cur);
    t = CW'(tgt);
    s = CW'(step);
    if (s == '0)
      r = tgt;
    else if (t > c)
      r = (c + s >= t) ? tgt : (DW+1)'(c + s);
    else
      r = (c >= t + s) ? (DW+1)'(c - s) : tgt;
    return r;
  endfunction

  assign cmd.cmd_ready = ena & rst_n;
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign b_evt         = ena & (cnt_q == CNT_MAX);
  assign duty_clamped  = (cmd.cmd_duty > FULL) ? FULL : cmd.cmd_duty;

  // Decode which channel the accepted command targets; out-of-range indices
  // match no channel and are dropped after the handshake.
  always_comb begin
    for (int i = 0; i < CH; i++)
      sel[i] = accept && (int'(cmd.cmd_ch) == i);
  end

  // Per-channel next state: command capture, ramp step at the boundary,
  // and FSM transitions. The boundary step uses the pre-command tgt/step.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      cur_d[i]   = cur_q[i];
      tgt_d[i]   = tgt_q[i];
      step_d[i]  = step_q[i];
      state_d[i] = state_q[i];
      done_d[i]  = 1'b0;

      if (sel[i]) begin
        tgt_d[i]  = duty_clamped;
        step_d[i] = cmd.cmd_step;
      end

      unique case (state_q[i])
        S_IDLE: begin
          if (tgt_d[i] != cur_q[i])
            state_d[i] = S_RAMP;
        end
        S_RAMP: begin
          if (b_evt)
            cur_d[i] = ramp_next(cur_q[i], tgt_q[i], step_q[i]);
          if (cur_d[i] == tgt_d[i]) begin
            state_d[i] = S_IDLE;
            done_d[i]  = b_evt;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Channel FSM state register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (!rst_n)
        state_q[i] <= S_IDLE;
      else
        state_q[i] <= state_d[i];
    end
  end

  // Period counter, per-channel duty registers and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      period_tick <= 1'b0;
      pwm_out     <= '0;
      done        <= '0;
      // NOTE: the per-channel arrays are small register files that must
      // restart from zero (reset aborts ramps), so they are reset explicitly.
      for (int i = 0; i < CH; i++) begin
        cur_q[i]  <= '0;
        tgt_q[i]  <= '0;
        step_q[i] <= '0;
      end
    end else begin
      if (ena)
        cnt_q <= cnt_q + 1'b1;
      period_tick <= b_evt;
      done        <= done_d;
      for (int i = 0; i < CH; i++) begin
        pwm_out[i] <= ena & ({1'b0, cnt_q} < cur_q[i]);
        cur_q[i]   <= cur_d[i];
        tgt_q[i]   <= tgt_d[i];
        step_q[i]  <= step_d[i];
      end
    end
  end

  // A channel is busy while its FSM is ramping.
  always_comb begin
    for (int i = 0; i < CH; i++)
      busy[i] = (state_q[i] == S_RAMP);
  end

`ifdef PWM_SEQ_IRQ_EN
  logic [CH-1:0] sticky_q;

  // Sticky done flags feeding a registered interrupt; a set beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= '0;
      irq      <= 1'b0;
    end else begin
      sticky_q <= (irq_clr ? '0 : sticky_q) | done;
      irq      <= |sticky_q;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer (CH=4, DW=5, STEP_W=3).
// A cycle-level reference model in plain integer arithmetic predicts every
// output each clock; directed steps walk the documented scenarios and a
// randomized phase follows.
module tb_pwm_ramp_sequencer;
  localparam int CH     = 4;
  localparam int DW     = 5;
  localparam int STEP_W = 3;
  localparam int P      = 1 << DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic [CH-1:0] pwm_out;
  logic [CH-1:0] busy;
  logic [CH-1:0] done;
  logic          period_tick;
`ifdef PWM_SEQ_IRQ_EN
  logic          irq;
  logic          irq_clr;
`endif

  int total = 0;
  int bad   = 0;

  pwm_ramp_sequencer_if #(.CH(CH), .DW(DW), .STEP_W(STEP_W)) cmd_if ();

  pwm_ramp_sequencer #(.CH(CH), .DW(DW), .STEP_W(STEP_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .cmd         (cmd_if),
    .pwm_out     (pwm_out),
    .busy        (busy),
    .done        (done),
    .period_tick (period_tick)
`ifdef PWM_SEQ_IRQ_EN
    ,
    .irq         (irq),
    .irq_clr     (irq_clr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state.
  int            m_cnt;
  int            m_cur  [CH];
  int            m_tgt  [CH];
  int            m_step [CH];
  logic [CH-1:0] e_pwm;
  logic [CH-1:0] e_busy;
  logic [CH-1:0] e_done;
  logic          e_tick;
`ifdef PWM_SEQ_IRQ_EN
  logic [CH-1:0] m_sticky;
  logic          e_irq;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    e_pwm  = '0;
    e_busy = '0;
    e_done = '0;
    e_tick = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_cur[i]  = 0;
      m_tgt[i]  = 0;
      m_step[i] = 0;
    end
`ifdef PWM_SEQ_IRQ_EN
    m_sticky = '0;
    e_irq    = 1'b0;
`endif
  endtask

  function automatic int ramp_ref(input int cur, input int tgt, input int step);
    if (step == 0)  return tgt;
    if (tgt > cur)  return (cur + step < tgt) ? cur + step : tgt;
    return (cur - step > tgt) ? cur - step : tgt;
  endfunction

  // One clock: check the combinational ready, advance the model at the edge,
  // then compare all registered outputs one time unit later.
  task automatic tick();
    logic acc;
    logic b;
    logic was;
    int   nc;
    int   ch;
    int   duty;
    #1;
    check("cmd_ready", 32'(cmd_if.cmd_ready), 32'(ena & rst_n));
    acc  = cmd_if.cmd_valid & ena & rst_n;
    ch   = int'(cmd_if.cmd_ch);
    duty = int'(cmd_if.cmd_duty);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      b = ena && (m_cnt == P - 1);
`ifdef PWM_SEQ_IRQ_EN
      e_irq    = |m_sticky;
      m_sticky = (irq_clr ? '0 : m_sticky) | e_done;
`endif
      e_tick = b;
      for (int i = 0; i < CH; i++) begin
        e_pwm[i] = ena && (m_cnt < m_cur[i]);
        was      = (m_cur[i] != m_tgt[i]);
        nc       = b ? ramp_ref(m_cur[i], m_tgt[i], m_step[i]) : m_cur[i];
        if (acc && ch == i) begin
          m_tgt[i]  = (duty > P) ? P : duty;
          m_step[i] = int'(cmd_if.cmd_step);
        end
        e_done[i] = b && was && (nc == m_tgt[i]);
        m_cur[i]  = nc;
        e_busy[i] = (m_cur[i] != m_tgt[i]);
      end
      if (ena) m_cnt = (m_cnt + 1) % P;
    end
    #1;
    check("pwm_out", 32'(pwm_out), 32'(e_pwm));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("period_tick", 32'(period_tick), 32'(e_tick));
`ifdef PWM_SEQ_IRQ_EN
    check("irq", 32'(irq), 32'(e_irq));
`endif
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int ch, input int duty, input int step);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_ch    = 2'(ch);
    cmd_if.cmd_duty  = 6'(duty);
    cmd_if.cmd_step  = 3'(step);
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic count_high(input int ch, output int n);
    n = 0;
    repeat (P) begin
      tick();
      n += int'(pwm_out[ch]);
    end
  endtask

  initial begin
    int n;
    rst_n            = 1'b0;
    ena              = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_ch    = '0;
    cmd_if.cmd_duty  = '0;
    cmd_if.cmd_step  = '0;
`ifdef PWM_SEQ_IRQ_EN
    irq_clr          = 1'b0;
`endif
    model_reset();

    // Reset held for three clocks with ena high: outputs and ready stay low.
    run(3);
    rst_n = 1'b1;

    // First period_tick lands 32 clocks after release.
    n = 0;
    do begin
      tick();
      n++;
    end while (!period_tick && n < 40);
    check("first_period_tick", 32'(n), 32'(P));

    // ch0 jumps to duty 8, then stays high 8 of every 32 clocks.
    send(0, 8, 0);
    run(P);
    count_high(0, n);
    check("ch0_high_clks", 32'(n), 32'd8);

    // ch1 ramps up 0 -> 20 by 6, then down 20 -> 3 by 7.
    send(1, 20, 6);
    run(5 * P);
    check("ch1_idle_after_up", 32'(busy[1]), 32'd0);
    send(1, 3, 7);
    run(4 * P);
    check("ch1_idle_after_down", 32'(busy[1]), 32'd0);

    // Over-range duty clamps to full scale; zero duty is constant low.
    send(1, 40, 0);
    run(2 * P);
    count_high(1, n);
    check("ch1_clamped_full", 32'(n), 32'(P));
    send(1, 0, 0);
    run(2 * P);
    count_high(1, n);
    check("ch1_zero_duty", 32'(n), 32'd0);

    // Retarget ch2 in the very clock of a boundary while it ramps.
    send(2, 30, 2);
    run(3 * P);
    n = 0;
    while (m_cnt != P - 1 && n < P) begin
      tick();
      n++;
    end
    send(2, 4, 1);
    run(6 * P);
    check("ch2_settled", 32'(busy[2]), 32'd0);

    // Reset in the middle of a ch3 ramp, then a 10-clock freeze.
    send(3, 32, 1);
    run(3 * P);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("busy_after_reset", 32'(busy), 32'd0);
    send(3, 20, 0);
    run(13);
    ena = 1'b0;
    run(10);
    ena = 1'b1;
    run(2 * P);

`ifdef PWM_SEQ_IRQ_EN
    // A done pulse raises irq; irq_clr drops it.
    send(0, 16, 0);
    run(P + 2);
    check("irq_raised", 32'(irq), 32'd1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    run(3);
    check("irq_cleared", 32'(irq), 32'd0);
`endif

    // Randomized phase: sparse commands, occasional freezes and resets.
    repeat (2000) begin
      ena   = ($urandom_range(0, 29) != 0);
      rst_n = ($urandom_range(0, 799) != 0);
      cmd_if.cmd_valid = ($urandom_range(0, 24) == 0);
      cmd_if.cmd_ch    = 2'($urandom_range(0, CH - 1));
      cmd_if.cmd_duty  = 6'($urandom_range(0, 63));
      cmd_if.cmd_step  = 3'($urandom_range(0, 7));
`ifdef PWM_SEQ_IRQ_EN
      irq_clr = ($urandom_range(0, 19) == 0);
`endif
      tick();
    end
    cmd_if.cmd_valid = 1'b0;
    rst_n = 1'b1;
    ena   = 1'b1;
    run(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
